hamming_emisor: RTL and testbench
=================================

// Module: hamming_emisor
// PURPOSE
//   Hamming(7,4) encoder (transmit side). Takes a 4-bit data nibble and produces a
//   7-bit codeword that corrects any single-bit error at the matching receiver.
//   Sits between the data source and the serializer/link; registered, one-cycle latency.
// PARAMETERS
//   REGISTER_OUTPUT  1  1: codeword registered (latency 1); 0: combinational path (latency 0)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous reset, active low
//   in_valid   in   1  d_in is valid this cycle
//   d_in       in   4  data nibble, d_in[0]=d1 ... d_in[3]=d4
//   out_valid  out  1  m_out holds a fresh codeword
//   m_out      out  7  codeword, bit i = Hamming position i+1
//   p_all      out  1  overall parity bit; present only with HAMMING_SECDED_EN
// BEHAVIOUR
//   - Single clock (clk), async active-low reset (rst_n). No other clocks or enables.
//   - Parity, all XOR:
//       p1 = d_in[0]^d_in[1]^d_in[3]
//       p2 = d_in[0]^d_in[2]^d_in[3]
//       p3 = d_in[1]^d_in[2]^d_in[3]
//   - Layout:
//       m_out = {d_in[3], d_in[2], d_in[1], p3, d_in[0], p2, p1}
//       i.e. [0]=p1 [1]=p2 [2]=d1 [3]=p3 [4]=d2 [5]=d3 [6]=d4
//   - REGISTER_OUTPUT=1:
//       - On each rising clk with in_valid=1: capture the encoded codeword and set out_valid=1.
//       - On each rising clk with in_valid=0: out_valid=0; m_out holds its last value.
//       - Back-to-back inputs accepted every cycle. No backpressure; throughput 1 word/cycle.
//   - REGISTER_OUTPUT=0: m_out = encode(d_in) and out_valid = in_valid, combinationally.
//     rst_n has no effect on outputs in this mode.
//   - Reset, registered mode: while rst_n=0, m_out=7'h00, out_valid=0, p_all=0,
//     asynchronously. A word being captured when reset asserts is discarded.
//     First capture happens on the first rising clk after rst_n deasserts.
//   - X or undefined d_in with in_valid=0 must not affect out_valid.
// CONFIGURATION
//   HAMMING_SECDED_EN defined:
//     - Adds output p_all = ^m_out (even parity over the 7 codeword bits), giving an
//       8-bit SECDED word {p_all, m_out}.
//     - p_all is registered/combinational exactly like m_out and resets to 0.
//   HAMMING_SECDED_EN undefined: no p_all port exists; behaviour otherwise identical.
// TESTING
//   1. Reset: rst_n=0 mid-run, no clk edge -> m_out=7'h00, out_valid=0 immediately.
//   2. Exhaustive sweep: d_in=0..15, in_valid=1 each cycle -> m_out=encode(d_in) one cycle
//      later. Spot checks:
//        0 -> 7'h00;  1 -> 7'h07;  4'hB -> 7'h55;  4'hF -> 7'h7F.
//   3. Code distance: for every pair of distinct codewords, Hamming distance >= 3.
//      Flipping any single m_out bit must be locatable by the syndrome
//      {p3,p2,p1} recomputed from the codeword.
//   4. Handshake: in_valid pattern 1,0,1 with d_in 1,F,B -> out_valid 1,0,1;
//      m_out 7'h07, 7'h07 (held), 7'h55.
//   5. HAMMING_SECDED_EN builds:
//        d_in=1 -> p_all=1;  d_in=4'hB -> p_all=0;  d_in=4'hF -> p_all=1.
//      Build without the macro and confirm it elaborates with no p_all port.
//   6. REGISTER_OUTPUT=0: change d_in with no clk edge -> m_out updates in the same
//      delta; out_valid tracks in_valid.

Source files
------------

// File: rtl/hamming_emisor.sv
// hamming_emisor: Hamming(7,4) encoder, registered or combinational per REGISTER_OUTPUT
// Define HAMMING_SECDED_EN to add the overall parity output p_all ({p_all, m_out} is SECDED).
module hamming_emisor #(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] d_in,
  output logic       out_valid,
  output logic [6:0] m_out
`ifdef HAMMING_SECDED_EN
  ,
  output logic       p_all
`endif
);
  logic p1, p2, p3;
  logic [6:0] code;
  always_comb begin
    p1   = d_in[0] ^ d_in[1] ^ d_in[3];
    p2   = d_in[0] ^ d_in[2] ^ d_in[3];
    p3   = d_in[1] ^ d_in[2] ^ d_in[3];
    code = {d_in[3], d_in[2], d_in[1], p3, d_in[0], p2, p1};
  end
  generate
    if (REGISTER_OUTPUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          m_out     <= 7'h00;
        end else begin
          out_valid <= in_valid;
          if (in_valid) m_out <= code;
        end
      end
    end else begin : g_comb
      assign out_valid = in_valid;
      assign m_out     = code;
    end
  endgenerate
`ifdef HAMMING_SECDED_EN
  // Derived from m_out so it follows the same latency and reset value.
  assign p_all = ^m_out;
`endif
endmodule

// File: tb/tb_hamming_emisor.sv
// tb_hamming_emisor: directed checks of hamming_emisor in registered and combinational modes
module tb_hamming_emisor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] d_in = 4'h0;
  logic       out_valid;
  logic [6:0] m_out;
  logic       iv_c = 1'b0;
  logic [3:0] d_c = 4'h0;
  logic       ov_c;
  logic [6:0] m_c;
  logic [6:0] cw [16];
  logic [6:0] flipped;
  logic [2:0] syn;
  int checks = 0;
  int errors = 0;
`ifdef HAMMING_SECDED_EN
  logic p_all, p_all_c;
`endif

  always #5 clk = ~clk;

  hamming_emisor #(.REGISTER_OUTPUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in),
    .out_valid(out_valid), .m_out(m_out)
`ifdef HAMMING_SECDED_EN
    , .p_all(p_all)
`endif
  );

  hamming_emisor #(.REGISTER_OUTPUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .d_in(d_c),
    .out_valid(ov_c), .m_out(m_c)
`ifdef HAMMING_SECDED_EN
    , .p_all(p_all_c)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic a, b, c;
    a = d[0] ^ d[1] ^ d[3];
    b = d[0] ^ d[2] ^ d[3];
    c = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], c, d[0], b, a};
  endfunction

  function automatic int popcnt(input logic [6:0] v);
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic cycle(input logic v, input logic [3:0] d);
    in_valid = v;
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_mout", {1'b0, m_out}, 8'h00);
    check("rst_ov", {7'b0, out_valid}, 8'h00);
    in_valid = 1'b1;
    d_in = 4'hF;
    @(posedge clk);
    #1;
    check("rst_hold_mout", {1'b0, m_out}, 8'h00);
    check("rst_hold_ov", {7'b0, out_valid}, 8'h00);
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      cycle(1'b1, 4'(v));
      check($sformatf("sweep_%0d", v), {1'b0, m_out}, {1'b0, enc(4'(v))});
      check("sweep_ov", {7'b0, out_valid}, 8'h01);
      cw[v] = m_out;
    end
    check("spot_0", {1'b0, cw[0]}, 8'h00);
    check("spot_1", {1'b0, cw[1]}, 8'h07);
    check("spot_b", {1'b0, cw[11]}, 8'h55);
    check("spot_f", {1'b0, cw[15]}, 8'h7F);
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++)
        check($sformatf("dist_%0d_%0d", i, j), {7'b0, popcnt(cw[i] ^ cw[j]) >= 3}, 8'h01);
    for (int v = 0; v < 16; v++)
      for (int b = 0; b < 7; b++) begin
        flipped = cw[v] ^ (7'd1 << b);
        syn[0] = flipped[0] ^ flipped[2] ^ flipped[4] ^ flipped[6];
        syn[1] = flipped[1] ^ flipped[2] ^ flipped[5] ^ flipped[6];
        syn[2] = flipped[3] ^ flipped[4] ^ flipped[5] ^ flipped[6];
        check($sformatf("syn_%0d_%0d", v, b), {5'b0, syn}, 8'(b + 1));
      end
    cycle(1'b1, 4'h1);
    check("hs1_ov", {7'b0, out_valid}, 8'h01);
    check("hs1_m", {1'b0, m_out}, 8'h07);
`ifdef HAMMING_SECDED_EN
    check("pall_1", {7'b0, p_all}, 8'h01);
`endif
    cycle(1'b0, 4'hF);
    check("hs2_ov", {7'b0, out_valid}, 8'h00);
    check("hs2_m", {1'b0, m_out}, 8'h07);
    cycle(1'b1, 4'hB);
    check("hs3_ov", {7'b0, out_valid}, 8'h01);
    check("hs3_m", {1'b0, m_out}, 8'h55);
`ifdef HAMMING_SECDED_EN
    check("pall_b", {7'b0, p_all}, 8'h00);
`endif
    cycle(1'b1, 4'hF);
`ifdef HAMMING_SECDED_EN
    check("pall_f", {7'b0, p_all}, 8'h01);
`endif
    in_valid = 1'b0;
    d_in = 4'bxxxx;
    @(posedge clk);
    #1;
    check("x_ov", {7'b0, out_valid}, 8'h00);
    check("x_hold_m", {1'b0, m_out}, 8'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_m", {1'b0, m_out}, 8'h00);
    check("async_rst_ov", {7'b0, out_valid}, 8'h00);
`ifdef HAMMING_SECDED_EN
    check("async_rst_pall", {7'b0, p_all}, 8'h00);
`endif
    #3;
    rst_n = 1'b1;
    cycle(1'b1, 4'hB);
    check("post_rst_m", {1'b0, m_out}, 8'h55);
    check("post_rst_ov", {7'b0, out_valid}, 8'h01);
    rst_n = 1'b0;
    iv_c = 1'b1;
    d_c = 4'hB;
    #1;
    check("comb_b", {1'b0, m_c}, 8'h55);
    check("comb_ov1", {7'b0, ov_c}, 8'h01);
    d_c = 4'h1;
    #1;
    check("comb_1", {1'b0, m_c}, 8'h07);
`ifdef HAMMING_SECDED_EN
    check("comb_pall", {7'b0, p_all_c}, 8'h01);
`endif
    iv_c = 1'b0;
    #1;
    check("comb_ov0", {7'b0, ov_c}, 8'h00);
    check("comb_hold", {1'b0, m_c}, 8'h07);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
